// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - single read cycles on an HD44780-compatible LCD bus
//
// Purpose: runs one LCD read cycle per accepted request. RS=0 returns the
// busy flag and address counter, RS=1 returns one DDRAM/CGRAM byte.
// Optional busy-poll feature: define LCD_READER_POLL_EN.
//
// Parameters:
//   SETUP_CLKS    cycles RS/RW stable before EN rises (1..15)
//   EN_HIGH_CLKS  cycles EN held high (1..31)
//   HOLD_CLKS     cycles RS/RW held after EN falls (1..15)
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   rd_req, rd_rs     read request and its register select (sampled in IDLE)
//   rd_ready          idle, accepts rd_req
//   rd_valid, rd_data one-cycle result pulse and captured byte
//   busy_flag         BF from the last status read
//   lcd_addr          AC from the last status read
//   lcd_busy          block owns the LCD pins
//   poll_start        start busy-poll (feature macro only)
//   poll_done         pulse when BF=0 is observed (feature macro only)
//   LCD_DATA_IN       LCD data pins, input path
//   LCD_EN, LCD_RW, LCD_RS  LCD control pins
module lcd_reader #(
  parameter int SETUP_CLKS   = 2,
  parameter int EN_HIGH_CLKS = 16,
  parameter int HOLD_CLKS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic       rd_rs,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] lcd_addr,
  output logic       lcd_busy,
  input  logic       poll_start,
  output logic       poll_done,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HIGH,
    S_HOLD,
    S_RESULT
  } state_t;

  // The counter holds "cycles remaining minus one" for the current state.
  localparam logic [4:0] SETUP_LOAD = 5'(SETUP_CLKS - 1);
  localparam logic [4:0] EN_LOAD    = 5'(EN_HIGH_CLKS - 1);
  localparam logic [4:0] HOLD_LOAD  = 5'(HOLD_CLKS - 1);

  state_t     state_q;
  logic [4:0] cnt_q;
  logic       rd_ready_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;
  logic       busy_flag_q;
  logic [6:0] lcd_addr_q;
  logic       lcd_busy_q;
  logic       en_q;
  logic       rw_q;
  logic       rs_q;

  logic       start_d;
  logic       start_rs_d;
  logic       poll_active;
  logic       cnt_zero;

  assign cnt_zero = (cnt_q == 5'd0);

`ifdef LCD_READER_POLL_EN
  logic poll_q;
  logic poll_done_q;

  // A pending poll outranks a host request and always reads status.
  assign poll_active = poll_q;
  assign start_d     = poll_start | poll_q | rd_req;
  assign start_rs_d  = (poll_start | poll_q) ? 1'b0 : rd_rs;
  assign poll_done   = poll_done_q;
`else
  logic unused_poll_start;

  assign unused_poll_start = poll_start;
  assign poll_active       = 1'b0;
  assign start_d           = rd_req;
  assign start_rs_d        = rd_rs;
  assign poll_done         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_ready_q  <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      busy_flag_q <= 1'b1;
      lcd_addr_q  <= '0;
      lcd_busy_q  <= 1'b0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      rs_q        <= 1'b0;
`ifdef LCD_READER_POLL_EN
      poll_q      <= 1'b0;
      poll_done_q <= 1'b0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
`ifdef LCD_READER_POLL_EN
      poll_done_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            state_q    <= S_SETUP;
            cnt_q      <= SETUP_LOAD;
            rs_q       <= start_rs_d;
            rw_q       <= 1'b1;
            rd_ready_q <= 1'b0;
            lcd_busy_q <= 1'b1;
`ifdef LCD_READER_POLL_EN
            poll_q     <= poll_start | poll_q;
`endif
          end
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state_q <= S_EN_HIGH;
            cnt_q   <= EN_LOAD;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_EN_HIGH: begin
          // Sample on the edge that drops EN; the LCD still drives the bus.
          if (cnt_zero) begin
            state_q   <= S_HOLD;
            cnt_q     <= HOLD_LOAD;
            en_q      <= 1'b0;
            rd_data_q <= LCD_DATA_IN;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state_q    <= S_RESULT;
            cnt_q      <= '0;
            rd_valid_q <= 1'b1;
            // Status fields update together with rd_valid.
            if (!rs_q) begin
              busy_flag_q <= rd_data_q[7];
              lcd_addr_q  <= rd_data_q[6:0];
            end
`ifdef LCD_READER_POLL_EN
            if (poll_q && !rd_data_q[7]) begin
              poll_done_q <= 1'b1;
              poll_q      <= 1'b0;
            end
`endif
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_RESULT: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          rw_q       <= 1'b0;
          rs_q       <= 1'b0;
          lcd_busy_q <= 1'b0;
          // While polling the host port stays closed between reads.
          rd_ready_q <= ~poll_active;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rd_ready  = rd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy_flag = busy_flag_q;
  assign lcd_addr  = lcd_addr_q;
  assign lcd_busy  = lcd_busy_q;
  assign LCD_EN    = en_q;
  assign LCD_RW    = rw_q;
  assign LCD_RS    = rs_q;

endmodule

// File: tb/tb_lcd_reader.sv
// tb/tb_lcd_reader.sv - scoreboard bench for lcd_reader
module tb_lcd_reader;

  localparam int S      = 2;
  localparam int E      = 16;
  localparam int H      = 2;
  localparam int LAT    = S + E + H;      // accept edge to the edge that raises rd_valid
  localparam int PERIOD = S + E + H + 2;  // SETUP..RESULT plus one IDLE cycle

  typedef struct {
    logic [7:0] data;
    logic       bf;
    logic [6:0] addr;
    int         vcyc;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd_req, rd_rs, poll_start;
  logic       rd_ready, rd_valid, busy_flag, lcd_busy, poll_done;
  logic [7:0] rd_data, LCD_DATA_IN, bus_val;
  logic [6:0] lcd_addr;
  logic       LCD_EN, LCD_RW, LCD_RS;

  logic       f_req, f_rs, f_ready, f_valid, f_bf, f_busy, f_pdone, f_en, f_rw, f_rsp;
  logic [7:0] f_data;
  logic [6:0] f_addr;
  logic [7:0] f_bus;

  logic       poll_mode = 1'b0;
  int         poll_idx = 0;
  logic [7:0] poll_seq [4];

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_valid = 0;
  int   en_cnt = 0;
  int   f_en_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // The model LCD only drives the bus while EN is high.
  assign LCD_DATA_IN = LCD_EN ? (poll_mode ? poll_seq[poll_idx] : bus_val) : 8'hEE;
  assign f_bus       = f_en ? 8'hC3 : 8'hEE;

  lcd_reader dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_rs(rd_rs),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy_flag(busy_flag), .lcd_addr(lcd_addr), .lcd_busy(lcd_busy),
    .poll_start(poll_start), .poll_done(poll_done), .LCD_DATA_IN(LCD_DATA_IN),
    .LCD_EN(LCD_EN), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS)
  );

  lcd_reader #(.SETUP_CLKS(1), .EN_HIGH_CLKS(1), .HOLD_CLKS(1)) dut_fast (
    .clk(clk), .reset(reset), .rd_req(f_req), .rd_rs(f_rs),
    .rd_ready(f_ready), .rd_valid(f_valid), .rd_data(f_data),
    .busy_flag(f_bf), .lcd_addr(f_addr), .lcd_busy(f_busy),
    .poll_start(1'b0), .poll_done(f_pdone), .LCD_DATA_IN(f_bus),
    .LCD_EN(f_en), .LCD_RW(f_rw), .LCD_RS(f_rsp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (f_en) f_en_cnt++;
  end

  // Monitor: pops the scoreboard on every rd_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        en_cnt = 0;
      end else begin
        if (LCD_EN) en_cnt++;
        if (rd_valid) begin
          n_valid++;
          check("sb_has_entry", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rd_data", rd_data, e.data);
            check("busy_flag", busy_flag, e.bf);
            check("lcd_addr", lcd_addr, e.addr);
            check("valid_cycle", cyc, e.vcyc);
            check("en_high_cycles", en_cnt, E);
            check("poll_done", poll_done, e.done);
          end
          en_cnt = 0;
          if (poll_mode) poll_idx++;
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200 && !rd_ready; i++) @(negedge clk);
    check("rd_ready_wait", rd_ready, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic push(input logic [7:0] d, input logic bf, input logic [6:0] a,
                      input int vc, input logic dn);
    exp_t e;
    e.data = d; e.bf = bf; e.addr = a; e.vcyc = vc; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic issue(input logic rs, input logic [7:0] bus, input logic [7:0] xd,
                       input logic xbf, input logic [6:0] xaddr);
    int t;
    wait_ready();
    bus_val = bus;
    rd_rs   = rs;
    rd_req  = 1'b1;
    t = cyc + 1;
    push(xd, xbf, xaddr, t + LAT, 1'b0);
    @(negedge clk);
    rd_req = 1'b0;
    rd_rs  = ~rs;  // must not matter after acceptance
    check("setup_rw", LCD_RW, 1);
    check("setup_rs", LCD_RS, rs);
    check("setup_en", LCD_EN, 0);
    check("setup_lcd_busy", lcd_busy, 1);
    check("setup_rd_ready", rd_ready, 0);
  endtask

  task automatic check_reset_vals();
    check("rst_rd_ready", rd_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_busy_flag", busy_flag, 1);
    check("rst_lcd_addr", lcd_addr, 7'h00);
    check("rst_lcd_busy", lcd_busy, 0);
    check("rst_lcd_en", LCD_EN, 0);
    check("rst_lcd_rw", LCD_RW, 0);
    check("rst_lcd_rs", LCD_RS, 0);
    check("rst_poll_done", poll_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, nv, fb;
    poll_seq[0] = 8'h80; poll_seq[1] = 8'h80; poll_seq[2] = 8'h05; poll_seq[3] = 8'h00;
    reset = 1'b0; rd_req = 1'b0; rd_rs = 1'b0; poll_start = 1'b0; bus_val = 8'h00;
    f_req = 1'b0; f_rs = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    @(negedge clk);

    // Directed single reads.
    issue(1'b0, 8'h8A, 8'h8A, 1'b1, 7'h0A); drain();
    issue(1'b1, 8'h41, 8'h41, 1'b1, 7'h0A); drain();
    issue(1'b0, 8'h23, 8'h23, 1'b0, 7'h23); drain();
    wait_ready();
    check("idle_rw", LCD_RW, 0);
    check("idle_rs", LCD_RS, 0);
    check("idle_lcd_busy", lcd_busy, 0);
    check("rd_data_hold", rd_data, 8'h23);

    // rd_req held high: three back-to-back data reads.
    bus_val = 8'h5A; rd_rs = 1'b1; rd_req = 1'b1;
    t = cyc + 1;
    for (int k = 0; k < 3; k++) push(8'h5A, 1'b0, 7'h23, t + k * PERIOD + LAT, 1'b0);
    for (int i = 0; i < 200 && cyc < t + 2 * PERIOD; i++) @(negedge clk);
    rd_req = 1'b0;
    check("b2b_third_accept", lcd_busy, 1);
    drain();

    // rd_req pulses while busy must not start extra reads.
    nv = n_valid;
    issue(1'b1, 8'hC9, 8'hC9, 1'b0, 7'h23);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!rd_ready) rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
    end
    drain();
    repeat (30) @(negedge clk);
    check("no_extra_reads", n_valid - nv, 1);

    // Reset in the middle of EN_HIGH.
    wait_ready();
    bus_val = 8'h77; rd_rs = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 0; i < 50 && !LCD_EN; i++) @(negedge clk);
    check("en_rose", LCD_EN, 1);
    repeat (3) @(negedge clk);
    nv = n_valid;
    #2 reset = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("no_valid_after_reset", n_valid - nv, 0);
    check("rd_data_discarded", rd_data, 8'h00);

`ifdef LCD_READER_POLL_EN
    wait_ready();
    poll_mode = 1'b1;
    rd_req = 1'b1; rd_rs = 1'b1;  // poll_start must win
    poll_start = 1'b1;
    t = cyc + 1;
    push(8'h80, 1'b1, 7'h00, t + LAT, 1'b0);
    push(8'h80, 1'b1, 7'h00, t + PERIOD + LAT, 1'b0);
    push(8'h05, 1'b0, 7'h05, t + 2 * PERIOD + LAT, 1'b1);
    @(negedge clk);
    poll_start = 1'b0; rd_req = 1'b0;
    check("poll_rs", LCD_RS, 0);
    for (int i = 0; i < 100 && cyc < t + LAT + 1; i++) @(negedge clk);
    check("poll_gap_ready", rd_ready, 0);
    check("poll_gap_lcd_busy", lcd_busy, 0);
    drain();
    poll_mode = 1'b0;
    wait_ready();
    check("poll_final_addr", lcd_addr, 7'h05);
    check("poll_final_bf", busy_flag, 0);
`else
    wait_ready();
    nv = n_valid;
    poll_start = 1'b1;
    @(negedge clk);
    poll_start = 1'b0;
    check("poll_ignored_busy", lcd_busy, 0);
    repeat (30) @(negedge clk);
    check("poll_ignored_reads", n_valid - nv, 0);
    check("poll_done_tied", poll_done, 0);
`endif

    // Minimum timing parameters on the second instance.
    for (int i = 0; i < 50 && !f_ready; i++) @(negedge clk);
    check("fast_ready", f_ready, 1);
    fb = f_en_cnt;
    f_rs = 1'b0; f_req = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    f_req = 1'b0;
    for (int i = 0; i < 20 && !f_valid; i++) @(negedge clk);
    check("fast_valid", f_valid, 1);
    check("fast_latency", cyc, t + 3);
    check("fast_en_cycles", f_en_cnt - fb, 1);
    check("fast_data", f_data, 8'hC3);
    check("fast_bf", f_bf, 1);
    check("fast_addr", f_addr, 7'h43);

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
